ssd_scan_ctrl: RTL and testbench
================================

Name: ssd_scan_ctrl

Overview:
Controller for the two-digit seven-segment display (PmodSSD, one shared segment bus, chip_sel picks the digit).
- Keeps a two-entry digit buffer filled by keypad key-press pulses.
- Encodes hex digits to segments.
- Sequences chip_sel, either auto-scanned (dual mode) or button-toggled (single mode).
- Inserts blanking dead time at every digit switch to suppress ghosting.
- Sits between the keypad decoder/pulse detectors and the top-level seg/chip_sel pins.

Parameters:
CLK_FREQ, 125_000_000, clk frequency in Hz
REFRESH_HZ, 500, full two-digit scan rate in Hz
BLANK_CYCLES, 125, segments-off cycles at each digit switch (>=1)
DWELL_CYCLES derived (localparam) = CLK_FREQ/(2*REFRESH_HZ) - BLANK_CYCLES; elaboration error if < 1

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
key_valid  input  1  one-cycle pulse, new key available
key_code  input  4  hex key value, sampled when key_valid=1
clear  input  1  one-cycle pulse, empties digit buffer
mode  input  1  0 = single (manual select), 1 = dual (auto scan)
sel_btn  input  1  one-cycle debounced pulse, toggles digit in single mode
seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered
chip_sel  output  1  0 = right digit, 1 = left digit, registered
digit_l  output  4  left buffer value
digit_r  output  4  right buffer value
entry_count  output  2  valid entries in buffer, 0..2

Behaviour:
- Reset (async): digit_l = digit_r = 0; valid_l = valid_r = 0; entry_count = 0; seg = 0; chip_sel = 0; FSM = SHOW_R; counter = 0.
- Buffer, right-entry shift:
  - On key_valid: digit_l <= digit_r, valid_l <= valid_r, digit_r <= key_code, valid_r <= 1.
  - entry_count saturates at 2.
  - clear: all valid flags 0, digits 0, count 0.
  - clear and key_valid in the same cycle: clear wins, key dropped.
- Encoding, hex 0..F -> 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
  - A digit whose valid flag is 0 displays seg = 00.
- FSM states: SHOW_R, BLANK_TO_L, SHOW_L, BLANK_TO_R.
  - In BLANK_* states seg = 00 and chip_sel already equals the target digit.
  - In SHOW_R, seg = enc(right); in SHOW_L, seg = enc(left).
- Dual mode (mode=1):
  - SHOW_x holds for DWELL_CYCLES, then goes to BLANK_TO_other.
  - BLANK_TO_x holds for BLANK_CYCLES, then goes to SHOW_x.
  - Counter clears on every state entry.
  - sel_btn is ignored.
- Single mode (mode=0):
  - Displayed value is always the right buffer entry (newest key), on whichever digit chip_sel selects.
  - No auto scan: SHOW_x holds indefinitely.
  - sel_btn in SHOW_R goes to BLANK_TO_L; in SHOW_L goes to BLANK_TO_R.
  - sel_btn during BLANK_* is ignored.
- Mode change (mode differs from its registered value):
  - Next state is BLANK_TO_R, counter cleared.
  - Applies to any change, including mid-blank.
- Latency:
  - seg/chip_sel are registered: they reflect FSM/buffer state one clk after it changes.
  - A key_valid at cycle n is visible on seg at n+2 if the right digit is currently shown.
- Buffer updates during a SHOW state take effect without restarting the dwell.
- Counter width is $clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1).

Test Plan:
(Bench overrides: CLK_FREQ=1000, REFRESH_HZ=50, BLANK_CYCLES=2, so DWELL_CYCLES=8.)
1. Reset, mode=1, no keys -> seg=00 throughout; chip_sel pattern 8 cycles 0, 10 cycles 1, 10 cycles 0, repeating; seg=00 during the 2 blank cycles after each toggle.
2. mode=1, keys 3 then A -> digit_l=3, digit_r=A, entry_count=2; seg=77 while chip_sel=0 in SHOW_R, seg=4F while chip_sel=1 in SHOW_L; seg=00 in blanks.
3. Three keys 1,2,5, then clear together with key_valid (code 7) -> after the third key digit_l=2, digit_r=5, count=2; after the clear cycle count=0 and seg=00 on both digits, key 7 not stored.
4. mode=0, key 6 -> chip_sel=0, seg=7D steady for more than 50 cycles; sel_btn -> chip_sel=1, 2 cycles seg=00, then seg=7D; sel_btn pulsed during those blank cycles -> ignored.
5. Mode toggled 1->0 while in SHOW_L -> next registered outputs chip_sel=0, seg=00 for 2 cycles, then SHOW_R held.
6. rst asserted mid-SHOW_L with count=2 -> immediately seg=00, chip_sel=0, count=0; after release the scan restarts with an 8-cycle SHOW_R.

Source files
------------

// File: rtl/ssd_scan_ctrl.sv
// Two-digit seven-segment controller: key-fed digit buffer, hex encoder and
// chip_sel sequencer with blanking dead time at every digit switch.
module ssd_scan_ctrl #(
  parameter int CLK_FREQ     = 125_000_000,
  parameter int REFRESH_HZ   = 500,
  parameter int BLANK_CYCLES = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       clear,
  input  logic       mode,
  input  logic       sel_btn,
  output logic [6:0] seg,
  output logic       chip_sel,
  output logic [3:0] digit_l,
  output logic [3:0] digit_r,
  output logic [1:0] entry_count
);

  localparam int DWELL_CYCLES = CLK_FREQ / (2 * REFRESH_HZ) - BLANK_CYCLES;
  localparam int CNT_MAX      = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW           = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  localparam logic [1:0] SHOW_R     = 2'd0;
  localparam logic [1:0] BLANK_TO_L = 2'd1;
  localparam logic [1:0] SHOW_L     = 2'd2;
  localparam logic [1:0] BLANK_TO_R = 2'd3;

  generate
    if (DWELL_CYCLES < 1) begin : g_bad_dwell
      $error("ssd_scan_ctrl: refresh rate leaves no dwell time after blanking");
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank
      $error("ssd_scan_ctrl: BLANK_CYCLES must be at least 1");
    end
  endgenerate

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      4'hF: hex_to_seg = 7'h71;
      default: hex_to_seg = 7'h00;
    endcase
  endfunction

  logic [3:0]    digit_l_r, digit_r_r;
  logic          valid_l_r, valid_r_r;
  logic [1:0]    count_r;
  logic [1:0]    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          mode_r;
  logic [6:0]    seg_r, seg_s;
  logic          chip_sel_r, chip_sel_s;
  logic          show_done_s, blank_done_s;

  // Digit buffer: new keys enter on the right and push the old right digit left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_l_r <= 4'h0;
      digit_r_r <= 4'h0;
      valid_l_r <= 1'b0;
      valid_r_r <= 1'b0;
      count_r   <= 2'd0;
    end else if (clear) begin
      digit_l_r <= 4'h0;
      digit_r_r <= 4'h0;
      valid_l_r <= 1'b0;
      valid_r_r <= 1'b0;
      count_r   <= 2'd0;
    end else if (key_valid) begin
      digit_l_r <= digit_r_r;
      valid_l_r <= valid_r_r;
      digit_r_r <= key_code;
      valid_r_r <= 1'b1;
      count_r   <= (count_r == 2'd2) ? 2'd2 : count_r + 2'd1;
    end else begin
      count_r   <= count_r;
    end
  end

  assign show_done_s  = mode_r ? (cnt_r == DWELL_LAST) : sel_btn;
  assign blank_done_s = (cnt_r == BLANK_LAST);

  // Next-state logic; a mode change always restarts from a blank toward the right digit.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (mode != mode_r) begin
      state_s = BLANK_TO_R;
      cnt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        SHOW_R: begin
          if (show_done_s) begin
            state_s = BLANK_TO_L;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s   = mode_r ? cnt_r + CNT_ONE : cnt_r;
          end
        end
        BLANK_TO_L: begin
          if (blank_done_s) begin
            state_s = SHOW_L;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
          end
        end
        SHOW_L: begin
          if (show_done_s) begin
            state_s = BLANK_TO_R;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s   = mode_r ? cnt_r + CNT_ONE : cnt_r;
          end
        end
        BLANK_TO_R: begin
          if (blank_done_s) begin
            state_s = SHOW_R;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = SHOW_R;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, dwell counter and last-seen mode; mode_r resets to dual so a
  // dual-mode start opens with a full right-digit dwell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= SHOW_R;
      cnt_r   <= CNT_ZERO;
      mode_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      mode_r  <= mode;
    end
  end

  // Output decode; single mode always shows the newest key on the selected digit.
  always_comb begin
    seg_s      = 7'h00;
    chip_sel_s = 1'b0;
    case (state_r)
      SHOW_R: begin
        chip_sel_s = 1'b0;
        seg_s      = valid_r_r ? hex_to_seg(digit_r_r) : 7'h00;
      end
      BLANK_TO_L: begin
        chip_sel_s = 1'b1;
        seg_s      = 7'h00;
      end
      SHOW_L: begin
        chip_sel_s = 1'b1;
        if (mode_r) begin
          seg_s = valid_l_r ? hex_to_seg(digit_l_r) : 7'h00;
        end else begin
          seg_s = valid_r_r ? hex_to_seg(digit_r_r) : 7'h00;
        end
      end
      BLANK_TO_R: begin
        chip_sel_s = 1'b0;
        seg_s      = 7'h00;
      end
      default: begin
        chip_sel_s = 1'b0;
        seg_s      = 7'h00;
      end
    endcase
  end

  // Pin registers for the shared segment bus and digit select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r      <= 7'h00;
      chip_sel_r <= 1'b0;
    end else begin
      seg_r      <= seg_s;
      chip_sel_r <= chip_sel_s;
    end
  end

  assign seg         = seg_r;
  assign chip_sel    = chip_sel_r;
  assign digit_l     = digit_l_r;
  assign digit_r     = digit_r_r;
  assign entry_count = count_r;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl with a 20-cycle scan period (8 dwell + 2 blank per digit).
module tb_ssd_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       clear = 1'b0;
  logic       mode = 1'b1;
  logic       sel_btn = 1'b0;
  logic [6:0] seg;
  logic       chip_sel;
  logic [3:0] digit_l, digit_r;
  logic [1:0] entry_count;

  ssd_scan_ctrl #(.CLK_FREQ(1000), .REFRESH_HZ(50), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .clear(clear), .mode(mode), .sel_btn(sel_btn), .seg(seg),
    .chip_sel(chip_sel), .digit_l(digit_l), .digit_r(digit_r),
    .entry_count(entry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       kv;
    logic [3:0] kc;
    logic       clr;
    logic       md;
    logic       sel;
    logic [6:0] seg;
    logic       cs;
    logic [3:0] dl;
    logic [3:0] dr;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  logic [6:0] enc_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // reference buffer contents after the most recent clock edge
  logic [3:0] m_l, m_r;
  logic       m_vl, m_vr;
  logic [1:0] m_cnt;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, expv);
    end
  endtask

  task automatic reset_model();
    m_l = 4'h0; m_r = 4'h0; m_vl = 1'b0; m_vr = 1'b0; m_cnt = 2'd0;
  endtask

  // one cycle: inputs before edge, expected outputs seen right after it
  task automatic add(input logic kv, input logic [3:0] kc, input logic clr, input logic md,
                     input logic sel, input logic [6:0] sg, input logic cs);
    vec_t v;
    if (clr) begin
      m_l = 4'h0; m_r = 4'h0; m_vl = 1'b0; m_vr = 1'b0; m_cnt = 2'd0;
    end else if (kv) begin
      m_l = m_r; m_vl = m_vr; m_r = kc; m_vr = 1'b1;
      if (m_cnt != 2'd2) m_cnt = m_cnt + 2'd1;
    end
    v.kv = kv; v.kc = kc; v.clr = clr; v.md = md; v.sel = sel;
    v.seg = sg; v.cs = cs; v.dl = m_l; v.dr = m_r; v.cnt = m_cnt;
    vecs.push_back(v);
  endtask

  // dual-mode cycle k after reset release: outputs reflect scan phase (k-1) mod 20
  task automatic add_dual(input int k, input logic kv, input logic [3:0] kc, input logic clr);
    int p;
    logic [6:0] sg;
    logic cs;
    p  = (k - 1) % 20;
    cs = (p >= 8 && p < 18);
    if (p inside {8, 9, 18, 19}) sg = 7'h00;
    else if (p < 8)              sg = m_vr ? enc_tab[m_r] : 7'h00;
    else                         sg = m_vl ? enc_tab[m_l] : 7'h00;
    add(kv, kc, clr, 1'b1, 1'b0, sg, cs);
  endtask

  task automatic run_vecs(input string tag);
    vec_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      key_valid = vecs[i].kv; key_code = vecs[i].kc; clear = vecs[i].clr;
      mode = vecs[i].md; sel_btn = vecs[i].sel;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("%s[%0d].seg", tag, i + 1), {1'b0, seg}, {1'b0, e.seg});
      check($sformatf("%s[%0d].chip_sel", tag, i + 1), {7'b0, chip_sel}, {7'b0, e.cs});
      check($sformatf("%s[%0d].digit_l", tag, i + 1), {4'b0, digit_l}, {4'b0, e.dl});
      check($sformatf("%s[%0d].digit_r", tag, i + 1), {4'b0, digit_r}, {4'b0, e.dr});
      check($sformatf("%s[%0d].count", tag, i + 1), {6'b0, entry_count}, {6'b0, e.cnt});
    end
    key_valid = 1'b0; clear = 1'b0; sel_btn = 1'b0;
    vecs.delete();
  endtask

  task automatic do_reset(input logic md);
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; clear = 1'b0; sel_btn = 1'b0; mode = md;
    @(posedge clk);
    #1;
    check("reset.seg", {1'b0, seg}, 8'h00);
    check("reset.chip_sel", {7'b0, chip_sel}, 8'h00);
    check("reset.count", {6'b0, entry_count}, 8'h00);
    check("reset.digits", {digit_l, digit_r}, 8'h00);
    rst = 1'b0;
    reset_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: blank display, dual-mode scan pattern
    do_reset(1'b1);
    for (int k = 1; k <= 60; k++) add_dual(k, 1'b0, 4'h0, 1'b0);
    run_vecs("scan");

    // 2: keys 3 then A shown on both digits
    do_reset(1'b1);
    for (int k = 1; k <= 45; k++) add_dual(k, (k <= 2), (k == 1) ? 4'h3 : 4'hA, 1'b0);
    run_vecs("two_keys");

    // 3: three keys then clear colliding with a key
    do_reset(1'b1);
    for (int k = 1; k <= 30; k++)
      add_dual(k, (k <= 4), (k == 1) ? 4'h1 : (k == 2) ? 4'h2 : (k == 3) ? 4'h5 : 4'h7, (k == 4));
    run_vecs("clear");

    // 4: single mode, manual select, sel_btn ignored in blank
    do_reset(1'b0);
    for (int k = 1; k <= 5; k++) add((k == 5), 4'h6, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    for (int k = 6; k <= 65; k++) add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 7'h7D, 1'b0);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 7'h7D, 1'b0);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 7'h00, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
    for (int k = 69; k <= 90; k++) add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 7'h7D, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 7'h7D, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    for (int k = 94; k <= 100; k++) add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 7'h7D, 1'b0);
    run_vecs("single");

    // 5: mode 1->0 while the left digit is shown
    do_reset(1'b1);
    for (int k = 1; k <= 13; k++) add_dual(k, (k <= 2), (k == 1) ? 4'h3 : 4'hA, 1'b0);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 7'h4F, 1'b1);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    for (int k = 17; k <= 50; k++) add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 7'h77, 1'b0);
    run_vecs("mode_chg");

    // 6: asynchronous reset mid left-digit dwell
    do_reset(1'b1);
    for (int k = 1; k <= 13; k++) add_dual(k, (k <= 2), (k == 1) ? 4'h3 : 4'hA, 1'b0);
    run_vecs("pre_rst");
    #1;
    rst = 1'b1;
    #1;
    check("async_rst.seg", {1'b0, seg}, 8'h00);
    check("async_rst.chip_sel", {7'b0, chip_sel}, 8'h00);
    check("async_rst.count", {6'b0, entry_count}, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
    for (int k = 1; k <= 12; k++) add_dual(k, 1'b0, 4'h0, 1'b0);
    run_vecs("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
